// File: rtl/sccb_config_sequencer.sv
// SCCB (3-phase write) register loader for the OV7670, driven from an external table.
// Optional NACK detection on the 9th bit of each phase: define SCCB_ACK_CHECK_EN.
module sccb_config_sequencer #(
    parameter int         QUARTER      = 63,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         MS_CYCLES    = 25000,
    parameter int         GAP_QUARTERS = 8
) (
    input  logic        clk_25,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sio_c,
    output logic        sio_d_out,
    output logic        sio_d_oe,
    input  logic        sio_d_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  write_count
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_BIT,
        S_STOP, S_GAP, S_DELAY, S_ADVANCE, S_DONE
    } state_t;

    state_t      state;
    logic [QW-1:0] qcnt;
    logic [1:0]  qidx;
    logic [4:0]  bcnt;
    logic [7:0]  gcnt;
    logic [23:0] shreg;
    logic [15:0] entry;
    logic [31:0] dcnt;
    logic        fcnt;
    logic        nack;
    logic        tick;

    assign tick = (qcnt == QW'(QUARTER - 1));

`ifndef SCCB_ACK_CHECK_EN
    logic unused_sio_d_in;
    assign unused_sio_d_in = sio_d_in;
`endif

    // Slots 8, 17 and 26 carry the don't-care/ACK bit of each phase
    function automatic logic is_ack(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            qcnt        <= '0;
            qidx        <= '0;
            bcnt        <= '0;
            gcnt        <= '0;
            shreg       <= '0;
            entry       <= '0;
            dcnt        <= '0;
            fcnt        <= 1'b0;
            nack        <= 1'b0;
            rom_addr    <= '0;
            sio_c       <= 1'b1;
            sio_d_out   <= 1'b1;
            sio_d_oe    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            write_count <= '0;
        end else begin
            if (state inside {S_START, S_BIT, S_STOP, S_GAP})
                qcnt <= tick ? '0 : qcnt + 1'b1;
            else
                qcnt <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        rom_addr    <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        write_count <= '0;
                        fcnt        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (fcnt) begin
                        entry <= rom_data;
                        fcnt  <= 1'b0;
                        state <= S_DECODE;
                    end else begin
                        fcnt <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (entry == 16'hFFFF) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (entry[15:8] == 8'hFE) begin
                        dcnt  <= 32'(entry[7:0]) * 32'(MS_CYCLES);
                        state <= (entry[7:0] == 8'h00) ? S_ADVANCE : S_DELAY;
                    end else begin
                        shreg <= {DEV_ADDR, entry};
                        bcnt  <= '0;
                        qidx  <= '0;
                        nack  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (qidx == 2'd0) begin
                            sio_d_out <= 1'b0;
                            qidx      <= 2'd1;
                        end else begin
                            state     <= S_BIT;
                            qidx      <= 2'd0;
                            bcnt      <= '0;
                            sio_c     <= 1'b0;
                            sio_d_oe  <= 1'b1;
                            sio_d_out <= shreg[23];
                            shreg     <= shreg << 1;
                        end
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        qidx <= qidx + 2'd1;
                        case (qidx)
                            2'd1: sio_c <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                            2'd2: begin
                                if (is_ack(bcnt) && sio_d_in) begin
                                    nack  <= 1'b1;
                                    error <= 1'b1;
                                end
                            end
`endif
                            2'd3: begin
                                sio_c <= 1'b0;
                                if (bcnt == 5'd26 || nack) begin
                                    state     <= S_STOP;
                                    sio_d_out <= 1'b0;
                                    sio_d_oe  <= 1'b1;
                                end else begin
                                    bcnt <= bcnt + 5'd1;
                                    if (is_ack(bcnt + 5'd1)) begin
                                        sio_d_oe  <= 1'b0;
                                        sio_d_out <= 1'b1;
                                    end else begin
                                        sio_d_oe  <= 1'b1;
                                        sio_d_out <= shreg[23];
                                        shreg     <= shreg << 1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        qidx <= qidx + 2'd1;
                        if (qidx == 2'd0) begin
                            sio_c <= 1'b1;
                        end else if (qidx == 2'd1) begin
                            sio_d_out <= 1'b1;
                        end else begin
                            qidx <= '0;
                            if (nack) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_GAP;
                                gcnt  <= '0;
                                if (write_count != 8'hFF)
                                    write_count <= write_count + 8'd1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (gcnt == 8'(GAP_QUARTERS - 1))
                            state <= S_ADVANCE;
                        else
                            gcnt <= gcnt + 8'd1;
                    end
                end
                S_DELAY: begin
                    if (dcnt <= 32'd1)
                        state <= S_ADVANCE;
                    else
                        dcnt <= dcnt - 32'd1;
                end
                S_ADVANCE: begin
                    if (rom_addr == 8'hFF) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + 8'd1;
                        fcnt     <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Programs OV7670 registers over SCCB (3-phase write) after power-up, from an external register table.
- Sits beside the camera control unit. It takes over the sio_c/sio_d lines that the camera control unit currently holds idle.
- Walks the table from entry 0 until an end marker and honours delay entries.
- Reports busy/done/error to the top level.

Parameters:
- QUARTER, 63: clk_25 cycles per SCCB quarter-bit (~99 kHz SCCB clock).
- DEV_ADDR, 8'h42: SCCB write ID sent in phase 1.
- MS_CYCLES, 25000: clk_25 cycles per millisecond for delay entries.
- GAP_QUARTERS, 8: idle quarters between consecutive transactions.

Ports:
- clk_25  in  1  system clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins table walk from entry 0
- rom_addr  out  8  table index, registered
- rom_data  in  16  {reg_addr[15:8], value[7:0]}; valid 1 cycle after rom_addr changes
- sio_c  out  1  SCCB clock
- sio_d_out  out  1  SCCB data out
- sio_d_oe  out  1  drive enable for sio_d pad (tri-state at top level)
- sio_d_in  in  1  SCCB data in (used only with ACK check)
- busy  out  1  sequence in progress
- done  out  1  level; table finished, held until next start
- error  out  1  level; NACK seen, cleared by start
- write_count  out  8  number of completed register writes

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk_25. All state lives in this one clock domain.
- Reset values:
  - sio_c=1, sio_d_out=1, sio_d_oe=1.
  - rom_addr=0, busy=0, done=0, error=0, write_count=0.
  - State IDLE; quarter counter and bit counter = 0.
- Reset mid-transaction returns to these values immediately. No stop condition is generated.
- A quarter tick is asserted when the counter reaches QUARTER-1; the counter then wraps to 0. The counter runs only in bus states.
- States:
  - IDLE: start goes to FETCH, sets rom_addr=0, busy=1, done=0, error=0, write_count=0.
  - DONE: behaves like IDLE except done=1.
  - FETCH: wait 2 clk_25 cycles, latch rom_data, go to DECODE.
  - DECODE:
    - 16'hFFFF goes to DONE.
    - reg_addr==8'hFE goes to DELAY, loaded with value*MS_CYCLES cycles. value=0 means no wait.
    - Anything else goes to START. Shift register = {DEV_ADDR, reg_addr, value}; phase counter = 0.
  - START: quarter 0 sio_c=1, sio_d=1; quarter 1 sio_d=0, sio_c=1; then BIT.
  - BIT: 27 bit slots, three phases of 8 data bits + 1 don't-care/ACK bit, MSB first. Each slot is 4 quarters:
    - q0: sio_c=0, update sio_d.
    - q1: sio_c=0.
    - q2: sio_c=1.
    - q3: sio_c=1.
    - For the 9th bit of each phase, sio_d_oe=0.
  - STOP:
    - q0: sio_c=0, sio_d=0, oe=1.
    - q1: sio_c=1, sio_d=0.
    - q2: sio_d=1.
    - Then GAP; write_count increments on entry to GAP.
  - GAP: GAP_QUARTERS quarters with the lines idle high, then ADVANCE.
  - DELAY: count down the loaded cycles, then ADVANCE.
  - ADVANCE:
    - If rom_addr==255, go to DONE (no wrap).
    - Otherwise rom_addr+1, go to FETCH.
- Outside BIT/STOP: sio_c=1, sio_d_out=1, oe=1.
- start while busy=1 is ignored.
- start and reset asserted together: reset wins.
- busy=0 in IDLE and DONE; busy=1 in all other states.
- write_count saturates at 255.

Optional Feature:
- Macro: SCCB_ACK_CHECK_EN.
- Defined:
  - sio_d_in is sampled at the q2→q3 boundary of each 9th bit.
  - If the sample is 1 (NACK): error=1, skip the remaining bits, go to STOP. After STOP go directly to DONE; no GAP, no write_count increment.
- Undefined:
  - The 9th bit is released and ignored, sio_d_in is unused, and error is always 0.

Test Plan:
- Table {16'h1280, 16'hFFFF}, QUARTER=4, start pulse:
  - Bus carries start, then 0x42, 0x12, 0x80 (27 slots, oe=0 on slots 9/18/27), then stop.
  - Each slot lasts 16 cycles. done=1, write_count=1, rom_addr=1.
- Table {16'hFE03, 16'h1104, 16'hFFFF}, MS_CYCLES=10:
  - sio_c is held at 1 for ≥30 cycles after start, then one write of 0x11/0x04 occurs. done=1, write_count=1.
- Table {16'hFFFF}:
  - No sio_c low pulse ever appears; done=1 within 5 cycles of start; write_count=0.
- Assert reset_n low during bit 10 of the first write:
  - Same cycle: sio_c=1, sio_d_out=1, oe=1, busy=0.
  - After release, a start re-runs the table from rom_addr=0.
- Pulse start mid-sequence:
  - No restart; the sequence completes normally.
  - A second start after done re-runs the whole table; done drops for the duration.
- With SCCB_ACK_CHECK_EN, sio_d_in=1 during the ACK slot of the sub-address phase:
  - Stop is issued; error=1, done=1, write_count=0, rom_addr=0.
